md_hilo: RTL
============

MD_HILO -- requirements
Module: md_hilo

Interface
REQ-001 SHALL have clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have resetn, input, 1, reset that is synchronous and active-low.
REQ-003 SHALL have md_valid, input, 1, request to start a multiply or divide.
REQ-004 SHALL have md_op, input, 2, operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have md_src1 and md_src2, input, 32 each: multiplicand/multiplier or dividend/divisor.
REQ-006 SHALL have md_ready, output, 1, high only in IDLE; a request is accepted on an edge where md_valid and md_ready are both 1.
REQ-007 SHALL have md_done, output, 1, one-cycle pulse marking that the result is in HI/LO.
REQ-008 SHALL have div_by_zero, output, 1, valid only while md_done is high.
REQ-009 SHALL have hi_wen/lo_wen (input, 1) and hi_wdata/lo_wdata (input, 32) for MTHI/MTLO writes.
REQ-010 SHALL have hi_rdata and lo_rdata, output, 32, driven directly by the HI and LO registers.

Function
REQ-011 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE; accept moves IDLE to CALC; CALC lasts exactly 32 cycles under a 5-bit counter; DONE lasts exactly 1 cycle.
REQ-012 SHALL number the accept edge E0, execute one shift-add (multiply) or one restoring-subtract (divide) step per cycle, register HI/LO and enter DONE at E32, and raise md_ready again from E33.
REQ-013 SHALL produce the 64-bit product for MULT/MULTU as HI = product[63:32] and LO = product[31:0].
REQ-014 SHALL set LO = quotient and HI = remainder for DIV/DIVU.
REQ-015 SHALL, for MULT/DIV, operate on operand magnitudes and then correct signs: product and quotient sign = src1[31]^src2[31]; remainder sign = dividend sign.
REQ-016 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, give LO = 0x80000000 and HI = 0 (wrap, no trap).
REQ-017 SHALL, for a divisor of 0 (DIV or DIVU), still take 32 CALC cycles, write HI = md_src1 and LO = 0xFFFFFFFF, and assert div_by_zero together with md_done.
REQ-018 SHALL latch operands and md_op at E0; later changes on md_src1, md_src2 and md_op SHALL have no effect.
REQ-019 SHALL ignore md_valid outside IDLE, with no queueing.
REQ-020 SHALL honour hi_wen/lo_wen only while md_ready = 1, writing at that edge, and ignore them otherwise.
REQ-021 SHALL, when hi_wen/lo_wen coincide with an accept in IDLE, perform the write; the later MD result then overwrites it.
REQ-022 SHALL hold HI/LO unchanged except on an MD completion or an honoured write.

Reset
REQ-023 SHALL, on any edge with resetn = 0 (including mid-CALC), go to IDLE and clear HI, LO and the counter to 0.
REQ-024 SHALL, during reset, drive md_done = 0, div_by_zero = 0 and md_ready = 1 after that edge.
REQ-025 SHALL discard an aborted operation and never signal it.

Configuration
REQ-026 SHALL use macro MD_FAST_MUL_EN to select the multiplier implementation.
REQ-027 SHALL, when MD_FAST_MUL_EN is defined, compute MULT/MULTU with a single-cycle array multiply: the E0 edge registers HI/LO and enters DONE directly, so md_done is high in the cycle after E0; divide is unchanged.
REQ-028 SHALL, when MD_FAST_MUL_EN is undefined, use the 32-cycle iterative multiply with timing per REQ-012.

Verification
REQ-029 SHALL cover: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001; md_done in the cycle after E32 (after E0 with MD_FAST_MUL_EN).
REQ-030 SHALL cover: MULT 0xFFFFFFFD (-3) x 5 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
REQ-031 SHALL cover: DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; DIVU 7 / 2 -> LO = 3, HI = 1.
REQ-032 SHALL cover: DIVU 0x1234 / 0 -> div_by_zero = 1 with md_done, HI = 0x00001234, LO = 0xFFFFFFFF.
REQ-033 SHALL cover: resetn low at CALC cycle 10 -> IDLE next edge, md_ready = 1, HI = LO = 0, no md_done pulse.
REQ-034 SHALL cover: hi_wen with 0xA5A5A5A5 while busy -> ignored; in IDLE -> hi_rdata = 0xA5A5A5A5 the next cycle; md_valid while busy -> no new operation.

Source files
------------

// File: rtl/md_hilo_if.sv
`default_nettype none
// ============================================================================
// Module      : md_hilo_if
// Description : Request/result and MTHI/MTLO bus between a core and md_hilo.
// Revision    : 1.0 - initial release
// ============================================================================
interface md_hilo_if;
    logic        md_valid;
    logic [1:0]  md_op;
    logic [31:0] md_src1;
    logic [31:0] md_src2;
    logic        md_ready;
    logic        md_done;
    logic        div_by_zero;
    logic        hi_wen;
    logic        lo_wen;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
    logic [31:0] hi_rdata;
    logic [31:0] lo_rdata;

    modport master (
        output md_valid, md_op, md_src1, md_src2,
        output hi_wen, lo_wen, hi_wdata, lo_wdata,
        input  md_ready, md_done, div_by_zero, hi_rdata, lo_rdata
    );

    modport slave (
        input  md_valid, md_op, md_src1, md_src2,
        input  hi_wen, lo_wen, hi_wdata, lo_wdata,
        output md_ready, md_done, div_by_zero, hi_rdata, lo_rdata
    );
endinterface
`default_nettype wire

// File: rtl/md_hilo.sv
`default_nettype none
// ============================================================================
// Module      : md_hilo
// Description : Iterative 32-bit multiply/divide unit with HI/LO registers.
//               MD_FAST_MUL_EN selects a single-cycle array multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module md_hilo (
    input  wire logic   clk,
    input  wire logic   resetn,
    md_hilo_if.slave    bus
);
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_ready;
    logic        r_done;
    logic        r_dbz;
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_src1;
    logic [31:0] r_b;
    logic [31:0] r_wh;
    logic [31:0] r_wl;

    logic        w_accept;
    logic        w_signed;
    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    logic [32:0] w_madd;
    logic [32:0] w_rem_sh;
    logic        w_qbit;
    logic [31:0] w_sub;
    logic [31:0] w_wh_nx;
    logic [31:0] w_wl_nx;
    logic [63:0] w_prod;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic        w_dbz;

    assign w_accept = bus.md_valid & r_ready;
    assign w_signed = ~bus.md_op[0];
    assign w_mag1   = (w_signed & bus.md_src1[31]) ? (32'd0 - bus.md_src1) : bus.md_src1;
    assign w_mag2   = (w_signed & bus.md_src2[31]) ? (32'd0 - bus.md_src2) : bus.md_src2;

    // Multiply: {r_wh,r_wl} shifts right, adding the multiplicand on a set LSB.
    assign w_madd   = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_b} : 33'd0);
    // Divide: restoring step on {r_wh,r_wl} shifted left; r_wh stays below r_b.
    assign w_rem_sh = {r_wh, r_wl[31]};
    assign w_qbit   = (w_rem_sh >= {1'b0, r_b});
    assign w_sub    = w_rem_sh[31:0] - r_b;

    always_comb begin
        w_wh_nx = {1'b0, w_madd[32:2], w_madd[1]};
        w_wl_nx = {w_madd[0], r_wl[31:1]};
        if (r_is_div) begin
            w_wh_nx = w_qbit ? w_sub : w_rem_sh[31:0];
            w_wl_nx = {r_wl[30:0], w_qbit};
        end
    end

    assign w_prod     = {w_wh_nx, w_wl_nx};
    assign w_prod_fix = r_neg_q ? (64'd0 - w_prod) : w_prod;
    assign w_quo      = r_neg_q ? (32'd0 - w_wl_nx) : w_wl_nx;
    assign w_rem      = r_neg_r ? (32'd0 - w_wh_nx) : w_wh_nx;
    assign w_dbz      = r_is_div & (r_b == 32'd0);

`ifdef MD_FAST_MUL_EN
    logic [63:0] w_ext1;
    logic [63:0] w_ext2;
    logic [63:0] w_fast_prod;
    assign w_ext1      = {{32{w_signed & bus.md_src1[31]}}, bus.md_src1};
    assign w_ext2      = {{32{w_signed & bus.md_src2[31]}}, bus.md_src2};
    assign w_fast_prod = w_ext1 * w_ext2;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 5'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.hi_wen) r_hi <= bus.hi_wdata;
                    if (bus.lo_wen) r_lo <= bus.lo_wdata;
                    if (w_accept) begin
                        r_is_div <= bus.md_op[1];
                        r_neg_q  <= w_signed & (bus.md_src1[31] ^ bus.md_src2[31]);
                        r_neg_r  <= w_signed & bus.md_src1[31];
                        r_src1   <= bus.md_src1;
                        r_b      <= w_mag2;
                        r_wh     <= 32'd0;
                        r_wl     <= w_mag1;
                        r_cnt    <= 5'd0;
                        r_ready  <= 1'b0;
                        r_state  <= c_ST_CALC;
`ifdef MD_FAST_MUL_EN
                        // Product lands in the accept edge; later assignment beats MTHI/MTLO.
                        if (!bus.md_op[1]) begin
                            r_hi    <= w_fast_prod[63:32];
                            r_lo    <= w_fast_prod[31:0];
                            r_done  <= 1'b1;
                            r_state <= c_ST_DONE;
                        end
`endif
                    end
                end
                c_ST_CALC: begin
                    r_wh  <= w_wh_nx;
                    r_wl  <= w_wl_nx;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= c_ST_DONE;
                        r_done  <= 1'b1;
                        r_dbz   <= w_dbz;
                        if (w_dbz) begin
                            r_hi <= r_src1;
                            r_lo <= 32'hFFFF_FFFF;
                        end else if (r_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end else begin
                            r_hi <= w_prod_fix[63:32];
                            r_lo <= w_prod_fix[31:0];
                        end
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.md_ready    = r_ready;
    assign bus.md_done     = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.hi_rdata    = r_hi;
    assign bus.lo_rdata    = r_lo;
endmodule
`default_nettype wire
